lfsr_seq_ctrl: RTL
==================

// Module: lfsr_seq_ctrl
// PURPOSE
//  Sequencer/arbiter for one shared free-running LFSR (seed/rst/sel/clk -> state datapath).
//  Drives LFSR reset, seed and tap-select; shares random words among NREQ requesters (round-robin).
//  Detects the all-zero lockup state, with automatic reseed. Sits between the LFSR instance and its consumers.
// PARAMETERS
//  W            4        LFSR state/seed width
//  NREQ         4        number of requesters (>=2)
//  SEED_HOLD    2        cycles lfsr_rst held high per seed operation (>=1)
//  DEFAULT_SEED {W{1'b1}} seed used after reset, on lockup, and in place of a zero cfg_seed
// PORTS
//  clk          in   1     clock, all logic on posedge
//  rst          in   1     asynchronous, active-low reset
//  cfg_seed     in   W     seed for reseed request
//  cfg_sel      in   1     tap-select for reseed request
//  cfg_load     in   1     1-cycle pulse: reseed with cfg_seed/cfg_sel
//  req          in   NREQ  per-requester request; held high until granted
//  gnt          out  NREQ  one-hot grant, 1-cycle pulse
//  rnd_data     out  W     random word, valid with gnt
//  rnd_valid    out  1     high exactly when gnt != 0
//  busy         out  1     high while seeding/warming (no grants)
//  lockup       out  1     1-cycle pulse on all-zero state detected
//  lfsr_rst     out  1     active-high reset to LFSR
//  lfsr_sel     out  1     tap-select to LFSR
//  lfsr_seed    out  W     seed to LFSR
//  lfsr_state   in   W     LFSR current state
// BEHAVIOUR
//  Reset (rst=0): state SEED, seed counter=0, gnt=0, rnd_valid=0, rnd_data=0, busy=1, lockup=0,
//   lfsr_rst=1, lfsr_sel=0, lfsr_seed=DEFAULT_SEED, rr pointer=0.
//  FSM: SEED -> WARM -> RUN.
//   SEED: lfsr_rst=1 for SEED_HOLD cycles after entry or after rst release -> WARM.
//   WARM: lfsr_rst=0, one cycle, state discarded -> RUN. busy=1 in SEED and WARM; busy=0 in RUN.
//  Grants (RUN only): req sampled each cycle; registered gnt/rnd_data/rnd_valid the next cycle
//   (1-cycle latency); rnd_data = lfsr_state at sample edge; at most one grant per cycle.
//  Round-robin: search starts at (last granted index + 1) mod NREQ. After reset it starts at 0.
//   The pointer updates only on a grant.
//  cfg_load in RUN: latch lfsr_seed=(cfg_seed==0 ? DEFAULT_SEED : cfg_seed), lfsr_sel=cfg_sel; go SEED.
//   A grant registered on the same edge still issues; no new grants are sampled.
//  cfg_load in SEED/WARM: relatch the seed and select, then restart SEED with its counter cleared.
//  Lockup: in RUN, lfsr_state==0 -> no grant sampled that cycle, lockup=1 next cycle.
//   lfsr_seed=DEFAULT_SEED, lfsr_sel unchanged, go SEED. cfg_load on the same cycle takes precedence and sets lockup=0.
//  lfsr_sel/lfsr_seed change only on SEED entry; they stay stable otherwise.
//  Mid-operation rst: immediate return to reset values; pending requests are dropped.
// CONFIGURATION
//  LFSR_PERIOD_MON_EN defined: adds outputs period[W:0] and period_valid.
//   On RUN entry, capture ref=lfsr_state and clear counter; counter increments each RUN cycle.
//   When lfsr_state==ref with count>0: period=count, period_valid 1-cycle pulse, counter restarts.
//   The counter saturates at all-ones, and then period_valid never fires. period=0 and period_valid=0 at reset and on SEED entry.
//  Not defined: the ports and logic are absent, and all other behaviour is identical.
// TESTING
//  1 rst=0 -> lfsr_rst=1, busy=1, gnt=0, lfsr_seed=4'b1111; release -> lfsr_rst high 2 cycles, 1 WARM cycle, busy=0 on the 4th edge.
//  2 RUN, req=4'b0100 held -> gnt=4'b0100, rnd_valid=1 next cycle, rnd_data==lfsr_state at sample edge; req dropped -> gnt=0.
//  3 RUN, req=4'b1111 held 8 cycles -> gnt 0001,0010,0100,1000,0001,0010,0100,1000.
//  4 RUN, cfg_load with cfg_seed=4'b1001, cfg_sel=1 -> lfsr_seed=1001, lfsr_sel=1, lfsr_rst 2 cycles, busy 3 cycles, no gnt meanwhile.
//  5 force lfsr_state=0 in RUN with req=0001 -> no gnt, lockup pulse, lfsr_seed=1111, reseed sequence; cfg_seed=0 load -> seed 1111.
//  6 LFSR_PERIOD_MON_EN, maximal-length 4-bit LFSR model, sel=0 -> period=15, period_valid every 15 cycles.

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer/arbiter for a shared LFSR: seeding, warm-up, round-robin word grants, lockup reseed.
// Optional period monitor enabled by defining LFSR_PERIOD_MON_EN.
module lfsr_seq_ctrl #(
    parameter int unsigned    W            = 4,
    parameter int unsigned    NREQ         = 4,
    parameter int unsigned    SEED_HOLD    = 2,
    parameter logic [W-1:0]   DEFAULT_SEED = {W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      cfg_seed,
    input  logic              cfg_sel,
    input  logic              cfg_load,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      rnd_data,
    output logic              rnd_valid,
    output logic              busy,
    output logic              lockup,
    output logic              lfsr_rst,
    output logic              lfsr_sel,
    output logic [W-1:0]      lfsr_seed,
`ifdef LFSR_PERIOD_MON_EN
    output logic [W:0]        period,
    output logic              period_valid,
`endif
    input  logic [W-1:0]      lfsr_state
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (SEED_HOLD > 1) ? $clog2(SEED_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(SEED_HOLD - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(NREQ - 1);
    localparam logic [PW:0]   NREQ_W    = (PW+1)'(NREQ);

    typedef enum logic [1:0] {ST_SEED, ST_WARM, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fresh_q, fresh_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [W-1:0]      rnd_data_q, rnd_data_d;
    logic              rnd_valid_q, rnd_valid_d;
    logic              lockup_q, lockup_d;
    logic              sel_q, sel_d;
    logic [W-1:0]      seed_q, seed_d;

    logic              lock;
    logic              hit;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     cand;
    logic [PW:0]       sum;

    assign lock = (state_q == ST_RUN) && (lfsr_state == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SEED;
            cnt_q       <= '0;
            fresh_q     <= 1'b1;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rnd_data_q  <= '0;
            rnd_valid_q <= 1'b0;
            lockup_q    <= 1'b0;
            sel_q       <= 1'b0;
            seed_q      <= DEFAULT_SEED;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fresh_q     <= fresh_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rnd_data_q  <= rnd_data_d;
            rnd_valid_q <= rnd_valid_d;
            lockup_q    <= lockup_d;
            sel_q       <= sel_d;
            seed_q      <= seed_d;
        end
    end

    // The first edge after reset release acts as the SEED entry edge, so the
    // hold count is the same whether SEED is entered from reset or from a reseed.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fresh_d  = 1'b0;
        seed_d   = seed_q;
        sel_d    = sel_q;
        lockup_d = 1'b0;
        if (cfg_load) begin
            seed_d  = (cfg_seed == '0) ? DEFAULT_SEED : cfg_seed;
            sel_d   = cfg_sel;
            state_d = ST_SEED;
            cnt_d   = '0;
        end else if (lock) begin
            seed_d   = DEFAULT_SEED;
            lockup_d = 1'b1;
            state_d  = ST_SEED;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_SEED: begin
                    if (!fresh_q) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = ST_WARM;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_WARM: state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        gnt_d       = '0;
        hit         = 1'b0;
        gidx        = ptr_q;
        ptr_d       = ptr_q;
        sum         = '0;
        cand        = '0;
        if (state_q == ST_RUN && !lock) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                sum = {1'b0, ptr_q} + (PW+1)'(i);
                if (sum >= NREQ_W) sum = sum - NREQ_W;
                cand = sum[PW-1:0];
                if (!hit && req[cand]) begin
                    hit  = 1'b1;
                    gidx = cand;
                end
            end
        end
        if (hit) begin
            gnt_d[gidx] = 1'b1;
            ptr_d       = (gidx == PTR_LAST) ? '0 : gidx + 1'b1;
        end
        rnd_data_d  = hit ? lfsr_state : rnd_data_q;
        rnd_valid_d = hit;
    end

    always_comb begin
        busy      = (state_q != ST_RUN);
        lfsr_rst  = (state_q == ST_SEED);
        gnt       = gnt_q;
        rnd_data  = rnd_data_q;
        rnd_valid = rnd_valid_q;
        lockup    = lockup_q;
        lfsr_sel  = sel_q;
        lfsr_seed = seed_q;
    end

`ifdef LFSR_PERIOD_MON_EN
    logic [W-1:0] ref_q, ref_d;
    logic [W:0]   pcnt_q, pcnt_d;
    logic [W:0]   period_q, period_d;
    logic         pv_q, pv_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_q    <= '0;
            pcnt_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
        end else begin
            ref_q    <= ref_d;
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
        end
    end

    // pcnt_q counts RUN edges since the reference was taken, so the edge that
    // sees the reference again reports pcnt_q + 1.
    always_comb begin
        ref_d    = ref_q;
        pcnt_d   = pcnt_q;
        period_d = period_q;
        pv_d     = 1'b0;
        if (cfg_load || lock) begin
            period_d = '0;
            pcnt_d   = '0;
        end else if (state_q == ST_WARM) begin
            ref_d  = lfsr_state;
            pcnt_d = '0;
        end else if (state_q == ST_RUN && pcnt_q != '1) begin
            if (lfsr_state == ref_q) begin
                period_d = pcnt_q + 1'b1;
                pv_d     = 1'b1;
                pcnt_d   = '0;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
`endif

endmodule
